// File: rtl/mem_arbiter_multi.sv
// Byte-serial memory access engine shared by NUM_CH requesters.
// Each grant runs one 1/2/4-byte load or store over an 8-bit bus; fixed-priority or round-robin.
module mem_arbiter_multi #(
  parameter int                NUM_CH     = 2,
  parameter int                ADDR_W     = 32,
  parameter int                ARB_MODE   = 0,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = '1,
  localparam int               CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic                   io_buffer_full,
  input  logic                   flush,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [ADDR_W-1:0]      mem_a,
  output logic                   mem_wr,
  input  logic [NUM_CH-1:0]      req_en,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH-1:0]      req_wr,
  input  logic [NUM_CH*2-1:0]    req_size,
  input  logic [NUM_CH-1:0]      req_signed,
  input  logic [NUM_CH*32-1:0]   req_wdata,
  output logic [NUM_CH-1:0]      req_rdy,
  output logic [31:0]            rdata,
  output logic                   busy,
  output logic [CH_W-1:0]        owner
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  logic [1:0]        state;
  logic [2:0]        issue_cnt;
  logic [2:0]        recv_cnt;
  logic [2:0]        n_q;
  logic              wr_q;
  logic              signed_q;
  logic              flushed;
  logic [31:0]       wdata_q;
  logic [7:0]        rbuf [4];
  logic [CH_W-1:0]   ptr;

  logic              en;
  logic [NUM_CH-1:0] cand;
  logic              grant_valid;
  logic [CH_W-1:0]   winner;
  logic [CH_W-1:0]   next_ptr;
  logic [1:0]        g_size;
  logic [2:0]        g_n;
  logic [31:0]       g_wdata;
  logic [7:0]        next_byte;
  logic [7:0]        ext;
  logic [31:0]       load_word;
  logic [NUM_CH-1:0] owner_hot;
  logic              own_flush;

  assign en        = rdy_in & ~io_buffer_full;
  assign owner_hot = NUM_CH'(1) << owner;
  assign own_flush = flush & FLUSH_MASK[owner];
  assign next_byte = 8'(wdata_q >> {issue_cnt + 3'd1, 3'b000});
  assign next_ptr  = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;

  // Flushed channels cannot win; round-robin scans upward from ptr with wrap.
  always_comb begin : arbitrate
    int              idx;
    logic [CH_W-1:0] sel;
    cand        = req_en & ~(flush ? FLUSH_MASK : '0);
    grant_valid = 1'b0;
    winner      = '0;
    idx         = 0;
    sel         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (ARB_MODE == 1) ? ((int'(ptr) + i) % NUM_CH) : i;
      sel = CH_W'(idx);
      if (!grant_valid && cand[sel]) begin
        grant_valid = 1'b1;
        winner      = sel;
      end
    end
  end

  // Unused store lanes are zeroed at grant so X never reaches mem_dout.
  always_comb begin
    g_size  = req_size[winner*2 +: 2];
    g_n     = (g_size == 2'd0) ? 3'd1 : (g_size == 2'd1) ? 3'd2 : 3'd4;
    g_wdata = req_wdata[winner*32 +: 32] &
              ((g_n == 3'd1) ? 32'h0000_00FF : (g_n == 3'd2) ? 32'h0000_FFFF : 32'hFFFF_FFFF);
  end

  always_comb begin
    ext       = (signed_q && n_q != 3'd4 && mem_din[7]) ? 8'hFF : 8'h00;
    load_word = '0;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < recv_cnt)       load_word[j*8 +: 8] = rbuf[j];
      else if (3'(j) == recv_cnt) load_word[j*8 +: 8] = mem_din;
      else                        load_word[j*8 +: 8] = ext;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      n_q       <= '0;
      wr_q      <= 1'b0;
      signed_q  <= 1'b0;
      flushed   <= 1'b0;
      wdata_q   <= '0;
      for (int j = 0; j < 4; j++) rbuf[j] <= '0;
      ptr       <= '0;
      mem_dout  <= '0;
      mem_a     <= '0;
      mem_wr    <= 1'b0;
      req_rdy   <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      owner     <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          req_rdy <= '0;
          if (grant_valid) begin
            mem_a     <= req_addr[winner*ADDR_W +: ADDR_W];
            mem_wr    <= req_wr[winner];
            mem_dout  <= g_wdata[7:0];
            wr_q      <= req_wr[winner];
            signed_q  <= req_signed[winner];
            n_q       <= g_n;
            wdata_q   <= g_wdata;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            flushed   <= 1'b0;
            busy      <= 1'b1;
            owner     <= winner;
            state     <= ACCESS;
            if (ARB_MODE == 1) ptr <= next_ptr;
          end
        end
        ACCESS: begin
          // A flushed speculative load is dropped; stores always finish on the bus.
          if (!wr_q && own_flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (wr_q && own_flush) flushed <= 1'b1;
            if (issue_cnt < n_q) begin
              issue_cnt <= issue_cnt + 3'd1;
              if (issue_cnt + 3'd1 < n_q) begin
                mem_a    <= mem_a + ADDR_W'(1);
                mem_dout <= next_byte;
              end
            end
            if (wr_q && issue_cnt == n_q - 3'd1) begin
              mem_wr  <= 1'b0;
              req_rdy <= (flushed || own_flush) ? '0 : owner_hot;
              state   <= COOLDOWN;
            end
            // mem_din lags the address by one cycle, so capture trails issue.
            if (!wr_q && recv_cnt < issue_cnt) begin
              recv_cnt             <= recv_cnt + 3'd1;
              rbuf[recv_cnt[1:0]]  <= mem_din;
              if (recv_cnt == n_q - 3'd1) begin
                rdata   <= load_word;
                req_rdy <= owner_hot;
                state   <= COOLDOWN;
              end
            end
          end
        end
        COOLDOWN: begin
          req_rdy <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_multi.sv
// Self-checking bench for mem_arbiter_multi: a fixed-priority 3-channel instance with
// a byte-array memory model, plus a round-robin instance checked for grant order.
module tb_mem_arbiter_multi;
  localparam int             NCH   = 3;
  localparam int             AW    = 32;
  localparam logic [NCH-1:0] FMASK = 3'b110;

  logic clk_in = 1'b0;
  logic rst_n_in, rdy_in, io_buffer_full, flush;
  logic [7:0]        mem_din, mem_dout;
  logic [AW-1:0]     mem_a;
  logic              mem_wr;
  logic [NCH-1:0]    req_en, req_wr, req_signed, req_rdy;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*2-1:0]  req_size;
  logic [NCH*32-1:0] req_wdata;
  logic [31:0]       rdata;
  logic              busy;
  logic [1:0]        owner;

  logic [NCH-1:0]    rr_req_en, rr_req_rdy;
  logic [7:0]        rr_mem_dout;
  logic [AW-1:0]     rr_mem_a;
  logic              rr_mem_wr, rr_busy;
  logic [31:0]       rr_rdata;
  logic [1:0]        rr_owner;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];

  int             obs_rdy_cyc;
  logic [31:0]    obs_rdata, obs_a_flush, obs_a_post;
  logic           obs_mem_wr, obs_busy_post;
  logic [NCH-1:0] obs_rdy_vec;
  logic [1:0]     obs_owner;
  bit             saw_x;

  mem_arbiter_multi #(.NUM_CH(NCH), .ADDR_W(AW), .ARB_MODE(0), .FLUSH_MASK(FMASK)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
    .flush(flush), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .req_en(req_en), .req_addr(req_addr), .req_wr(req_wr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata), .req_rdy(req_rdy), .rdata(rdata),
    .busy(busy), .owner(owner));

  mem_arbiter_multi #(.NUM_CH(NCH), .ADDR_W(AW), .ARB_MODE(1)) dut_rr (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
    .flush(1'b0), .mem_din(8'h00), .mem_dout(rr_mem_dout), .mem_a(rr_mem_a), .mem_wr(rr_mem_wr),
    .req_en(rr_req_en), .req_addr('0), .req_wr('0), .req_size('0),
    .req_signed('0), .req_wdata('0), .req_rdy(rr_req_rdy), .rdata(rr_rdata),
    .busy(rr_busy), .owner(rr_owner));

  always #5 clk_in = ~clk_in;

  // Synchronous byte memory with one-cycle read latency; frozen while the system is stalled.
  always @(posedge clk_in) begin
    if (rdy_in && !io_buffer_full) begin
      if (mem_wr) mem[mem_a[11:0]] <= mem_dout;
      mem_din <= mem[mem_a[11:0]];
    end
  end

  function automatic int size_n(input int sz);
    return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int sz, input bit sgn);
    int          n;
    logic [31:0] v;
    logic [11:0] ix;
    n = size_n(sz);
    v = '0;
    for (int i = 0; i < n; i++) begin
      ix = 12'(addr + 32'(i));
      v  = v | (32'(ref_mem[ix]) << (8 * i));
    end
    ix = 12'(addr + 32'(n - 1));
    if (sgn && n < 4 && ref_mem[ix][7]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic poke(input logic [31:0] addr, input logic [7:0] b);
    mem[addr[11:0]]     = b;
    ref_mem[addr[11:0]] = b;
  endtask

  task automatic model_store(input logic [31:0] addr, input int sz, input logic [31:0] wd);
    logic [11:0] ix;
    for (int i = 0; i < size_n(sz); i++) begin
      ix          = 12'(addr + 32'(i));
      ref_mem[ix] = wd[i*8 +: 8];
    end
  endtask

  // Drives one request and records what the DUT did; cycles count unstalled edges since request.
  task automatic run_access(input int ch, input logic [31:0] addr, input bit wr, input int sz,
                            input bit sgn, input logic [31:0] wdata, input bit stalls, input int flush_at);
    int cyc;
    int edges;
    bit en_now;
    cyc   = 0;
    edges = 0;
    saw_x = 0;
    req_en = '0;
    req_en[ch]              = 1'b1;
    req_addr[ch*AW +: AW]   = addr;
    req_wr[ch]              = wr;
    req_size[ch*2 +: 2]     = 2'(sz);
    req_signed[ch]          = sgn;
    req_wdata[ch*32 +: 32]  = wdata;
    obs_rdy_cyc = -1;
    while (edges < 60 && obs_rdy_cyc < 0) begin
      if (stalls) begin
        rdy_in         = ($urandom_range(0, 3) != 0);
        io_buffer_full = ($urandom_range(0, 4) == 0);
      end
      if (cyc == flush_at) begin
        rdy_in = 1'b1; io_buffer_full = 1'b0; flush = 1'b1;
        obs_a_flush = mem_a;
        if (FMASK[ch]) req_en[ch] = 1'b0;
      end else begin
        flush = 1'b0;
      end
      en_now = rdy_in && !io_buffer_full;
      @(posedge clk_in);
      @(negedge clk_in);
      edges++;
      if (en_now) cyc++;
      if ($isunknown(mem_dout)) saw_x = 1;
      if (flush_at >= 0 && en_now && cyc == flush_at + 1) begin
        obs_busy_post = busy;
        obs_a_post    = mem_a;
      end
      if (req_rdy != '0) begin
        obs_rdy_cyc = cyc;
        obs_rdata   = rdata;
        obs_mem_wr  = mem_wr;
        obs_owner   = owner;
        obs_rdy_vec = req_rdy;
      end
    end
    flush = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; req_en = '0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (mem_a !== '0 || mem_dout !== 8'h00 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL reset_bus got a=%h d=%h wr=%b exp 0", mem_a, mem_dout, mem_wr); end
    checks++; if (rdata !== 32'h0 || req_rdy !== '0 || owner !== 2'd0) begin
      errors++; $display("FAIL reset_out got rdata=%h rdy=%b owner=%0d exp 0", rdata, req_rdy, owner); end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_fixed_prio();
    int          cyc;
    int          got;
    int          cyc_seen [2];
    logic [2:0]  vec_seen [2];
    logic [31:0] dat_seen [2];
    logic [31:0] exp1;
    poke(32'h100, 8'hEF); poke(32'h101, 8'hBE); poke(32'h102, 8'hAD); poke(32'h103, 8'hDE);
    exp1 = model_load(32'h200, 2, 0);
    req_addr[0*AW +: AW] = 32'h100; req_addr[1*AW +: AW] = 32'h200;
    req_wr = '0; req_signed = '0; req_size = 6'b00_10_10;
    req_en = 3'b011;
    cyc = 0; got = 0;
    while (got < 2 && cyc < 40) begin
      @(posedge clk_in); @(negedge clk_in);
      cyc++;
      if (req_rdy != '0) begin
        cyc_seen[got] = cyc; vec_seen[got] = req_rdy; dat_seen[got] = rdata;
        req_en = req_en & ~req_rdy;
        got++;
      end
    end
    req_en = '0;
    repeat (3) @(negedge clk_in);
    checks++; if (got != 2) begin errors++; $display("FAIL prio_count got %0d completions exp 2", got); end
    else begin
      checks++; if (vec_seen[0] !== 3'b001 || cyc_seen[0] != 6) begin errors++;
        $display("FAIL prio_first got rdy=%b cyc=%0d exp 001 cyc 6", vec_seen[0], cyc_seen[0]); end
      checks++; if (dat_seen[0] !== 32'hDEADBEEF) begin errors++;
        $display("FAIL prio_rdata0 got %h exp deadbeef", dat_seen[0]); end
      checks++; if (vec_seen[1] !== 3'b010 || cyc_seen[1] != 13 || dat_seen[1] !== exp1) begin errors++;
        $display("FAIL prio_second got rdy=%b cyc=%0d data=%h exp 010 cyc 13 data=%h",
                 vec_seen[1], cyc_seen[1], dat_seen[1], exp1); end
    end
  endtask

  task automatic test_load_ext();
    int          ch, sz;
    bit          sg;
    logic [31:0] a, exp;
    poke(32'h10, 8'h80); poke(32'h11, 8'hFF);
    run_access(0, 32'h10, 0, 0, 1, 32'h0, 0, -1);
    checks++; if (obs_rdata !== 32'hFFFFFF80 || obs_rdy_cyc != 3) begin errors++;
      $display("FAIL lb got %h cyc %0d exp ffffff80 cyc 3", obs_rdata, obs_rdy_cyc); end
    run_access(1, 32'h10, 0, 0, 0, 32'h0, 0, -1);
    checks++; if (obs_rdata !== 32'h00000080) begin errors++;
      $display("FAIL lbu got %h exp 00000080", obs_rdata); end
    run_access(2, 32'h10, 0, 1, 1, 32'h0, 0, -1);
    checks++; if (obs_rdata !== 32'hFFFFFF80 || obs_rdy_cyc != 4) begin errors++;
      $display("FAIL lh got %h cyc %0d exp ffffff80 cyc 4", obs_rdata, obs_rdy_cyc); end
    for (int k = 0; k < 10; k++) begin
      ch  = $urandom_range(0, NCH - 1);
      sz  = $urandom_range(0, 3);
      sg  = 1'($urandom_range(0, 1));
      a   = (k == 0) ? 32'hFFFF_FFFE : ((32'($urandom_range(0, 1)) << 31) | 32'($urandom_range(0, 4095)));
      exp = model_load(a, sz, sg);
      run_access(ch, a, 0, sz, sg, 32'h0, 0, -1);
      checks++; if (obs_rdy_cyc != size_n(sz) + 2 || obs_rdy_vec !== 3'(1 << ch)) begin errors++;
        $display("FAIL load_timing k=%0d got cyc %0d rdy %b exp cyc %0d rdy %b",
                 k, obs_rdy_cyc, obs_rdy_vec, size_n(sz) + 2, 3'(1 << ch)); end
      checks++; if (obs_rdata !== exp) begin errors++;
        $display("FAIL load_data k=%0d a=%h sz=%0d s=%0d got %h exp %h", k, a, sz, sg, obs_rdata, exp); end
    end
  endtask

  task automatic test_store();
    int          ch, sz, n;
    bit          bad;
    logic [31:0] a, wd;
    logic [11:0] ix;
    model_store(32'h3000, 1, 32'h12345678);
    run_access(0, 32'h3000, 1, 1, 0, 32'h12345678, 0, -1);
    checks++; if (obs_rdy_cyc != 3 || obs_mem_wr !== 1'b0) begin errors++;
      $display("FAIL sh_timing got cyc %0d wr %b exp cyc 3 wr 0", obs_rdy_cyc, obs_mem_wr); end
    checks++; if (mem[12'h000] !== 8'h78 || mem[12'h001] !== 8'h56 || mem[12'h002] !== ref_mem[12'h002]) begin
      errors++; $display("FAIL sh_bytes got %h %h %h exp 78 56 %h",
                         mem[12'h000], mem[12'h001], mem[12'h002], ref_mem[12'h002]); end
    for (int k = 0; k < 8; k++) begin
      ch = $urandom_range(0, NCH - 1);
      sz = $urandom_range(0, 3);
      n  = size_n(sz);
      a  = 32'($urandom_range(0, 4095));
      wd = $urandom;
      model_store(a, sz, wd);
      for (int j = 0; j < 4; j++) if (j >= n) wd[j*8 +: 8] = 8'hxx;
      run_access(ch, a, 1, sz, 0, wd, 0, -1);
      checks++; if (obs_rdy_cyc != n + 1 || obs_rdy_vec !== 3'(1 << ch) || saw_x) begin errors++;
        $display("FAIL store_timing k=%0d got cyc %0d rdy %b x %0d exp cyc %0d rdy %b x 0",
                 k, obs_rdy_cyc, obs_rdy_vec, saw_x, n + 1, 3'(1 << ch)); end
      bad = 0;
      for (int i = 0; i <= n; i++) begin
        ix = 12'(a + 32'(i));
        if (mem[ix] !== ref_mem[ix]) bad = 1;
      end
      checks++; if (bad) begin errors++;
        $display("FAIL store_bytes k=%0d a=%h n=%0d got %h exp %h", k, a, n, mem[a[11:0]], ref_mem[a[11:0]]); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, wd, exp;
    bit          bad;
    logic [11:0] ix;
    prev = rdata;
    run_access(1, 32'h100, 0, 2, 0, 32'h0, 0, 2);
    checks++; if (obs_rdy_cyc != -1 || obs_busy_post !== 1'b0) begin errors++;
      $display("FAIL flush_load got rdy cyc %0d busy %b exp none busy 0", obs_rdy_cyc, obs_busy_post); end
    checks++; if (obs_a_post !== obs_a_flush || rdata !== prev || busy !== 1'b0) begin errors++;
      $display("FAIL flush_hold got a=%h rdata=%h busy=%b exp a=%h rdata=%h busy=0",
               obs_a_post, rdata, busy, obs_a_flush, prev); end
    wd = $urandom;
    model_store(32'h400, 2, wd);
    run_access(1, 32'h400, 1, 2, 0, wd, 0, 2);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      ix = 12'(32'h400 + 32'(i));
      if (mem[ix] !== ref_mem[ix]) bad = 1;
    end
    checks++; if (obs_rdy_cyc != -1 || bad) begin errors++;
      $display("FAIL flush_store got rdy cyc %0d bytes_bad %0d exp none 0", obs_rdy_cyc, bad); end
    exp = model_load(32'h400, 2, 0);
    run_access(0, 32'h400, 0, 2, 0, 32'h0, 0, 2);
    checks++; if (obs_rdy_cyc != 6 || obs_rdata !== exp) begin errors++;
      $display("FAIL flush_unmasked got cyc %0d data %h exp cyc 6 data %h", obs_rdy_cyc, obs_rdata, exp); end
  endtask

  task automatic test_stall();
    int          sz;
    logic [31:0] a, exp;
    for (int k = 0; k < 5; k++) begin
      sz  = (k == 0) ? 2 : $urandom_range(0, 3);
      a   = 32'($urandom_range(0, 4095));
      exp = model_load(a, sz, 1);
      run_access(k % NCH, a, 0, sz, 1, 32'h0, 1, -1);
      checks++; if (obs_rdy_cyc != size_n(sz) + 2 || obs_rdata !== exp) begin errors++;
        $display("FAIL stall_load k=%0d got cyc %0d data %h exp cyc %0d data %h",
                 k, obs_rdy_cyc, obs_rdata, size_n(sz) + 2, exp); end
    end
  endtask

  task automatic test_round_robin();
    int         ptr, win, idx, edges;
    bit         got;
    logic [2:0] mask;
    ptr = 0;
    for (int r = 0; r < 16; r++) begin
      mask = (r < 6) ? 3'b111 : 3'($urandom_range(1, 7));
      rr_req_en = mask;
      win = -1;
      for (int i = 0; i < NCH; i++) begin
        idx = (ptr + i) % NCH;
        if (win < 0 && mask[idx]) win = idx;
      end
      ptr = (win + 1) % NCH;
      got = 0; edges = 0;
      while (!got && edges < 20) begin
        @(posedge clk_in); @(negedge clk_in);
        edges++;
        if (rr_req_rdy != '0) got = 1;
      end
      checks++; if (!got || rr_req_rdy !== 3'(1 << win) || rr_owner !== 2'(win)) begin errors++;
        $display("FAIL rr_grant r=%0d mask=%b got rdy %b owner %0d exp channel %0d",
                 r, mask, rr_req_rdy, rr_owner, win); end
    end
    rr_req_en = '0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_reset_mid();
    req_en = 3'b001;
    req_addr[0 +: AW] = 32'h123; req_wr[0] = 1'b0; req_size[1:0] = 2'b10; req_signed[0] = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got %b exp 1", busy); end
    #2 rst_n_in = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || mem_a !== '0 || rdata !== '0 || owner !== 2'd0 ||
                  req_rdy !== '0 || mem_wr !== 1'b0 || mem_dout !== 8'h00) begin errors++;
      $display("FAIL midreset_outputs got busy=%b a=%h rdata=%h owner=%0d exp all 0",
               busy, mem_a, rdata, owner); end
    req_en = '0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    req_en = '0; req_wr = '0; req_signed = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    rr_req_en = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_fixed_prio();
    test_load_ext();
    test_store();
    test_flush();
    test_stall();
    test_round_robin();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
